taus_seed_loader: RTL
=====================

// Module: taus_seed_loader
// PURPOSE
//  Seeding front end for the Tausworthe uniform generator in the Box-Muller RNG.
//  Accepts three 32-bit seed words (s0, s1, s2) over a valid/ready stream and
//  repairs seeds below the Tausworthe minimums. Drives the generator's seed
//  inputs and its reset, then holds off rng_ready for a warm-up period so
//  downstream logic never consumes freshly seeded (correlated) outputs.
// PARAMETERS
//  WARMUP      8              cycles taus runs after load before rng_ready=1 (>=1)
//  DEFAULT_S0  32'h0000_1234  substitute for s0 < 2
//  DEFAULT_S1  32'h0000_5678  substitute for s1 < 8
//  DEFAULT_S2  32'h0009_ABCD  substitute for s2 < 16
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  reset       in   1   system reset, synchronous, active-high
//  seed_valid  in   1   seed_data holds a word
//  seed_data   in   32  seed word, order s0, s1, s2
//  seed_ready  out  1   loader accepts a word this cycle
//  taus_rst    out  1   reset/seed-load strobe to generator (active-high)
//  taus_s0     out  32  seed s0 to generator
//  taus_s1     out  32  seed s1 to generator
//  taus_s2     out  32  seed s2 to generator
//  seed_fixed  out  3   bit i = seed si was replaced by DEFAULT_Si at last load
//  rng_ready   out  1   generator output valid for consumption
// BEHAVIOUR
//  - All outputs registered. Word transfer = seed_valid & seed_ready at posedge.
//  - Reset values: state IDLE, word_cnt 0, seed_ready 1, taus_rst 1,
//    taus_s0/1/2 = DEFAULT_S0/1/2, seed_fixed 3'b000, rng_ready 0, warm_cnt 0.
//  - States:
//    IDLE    : taus_rst=1 (generator frozen), seed_ready=1. Transfer -> COLLECT, word_cnt=1.
//    COLLECT : seed_ready=1; words 2 and 3 captured. After third transfer -> LOAD.
//              No timeout; seed_valid low simply stalls. taus_rst unchanged.
//    LOAD    : one cycle; taus_rst=1, seed_ready=0; taus_s* = validated seeds,
//              already stable on the edge entering LOAD. -> WARM, warm_cnt=0.
//    WARM    : taus_rst=0, seed_ready=0; warm_cnt increments each cycle;
//              after WARMUP cycles -> READY.
//    READY   : rng_ready=1, seed_ready=1, taus_rst=0. Transfer (re-seed) ->
//              COLLECT, rng_ready=0 from next edge; generator keeps running on old
//              seed until LOAD.
//  - Validation at 3rd-word edge, compares unsigned: s0<2, s1<8, s2<16 -> default
//    substituted, matching seed_fixed bit set; other bits cleared. Seeds at the
//    exact minimum (2, 8, 16) pass unchanged.
//  - Latency: 3rd word accepted at edge k -> taus_rst=1 during cycle k..k+1,
//    taus_rst=0 from edge k+1, rng_ready=1 from edge k+1+WARMUP.
//  - Captured words are held in staging registers; taus_s* change only on entry to
//    LOAD and never during WARM/READY.
//  - seed_ready is a function of state only, independent of seed_valid.
//  - reset in any state (including mid-COLLECT or WARM) discards partial words and
//    returns to reset values within one edge.
//  - warm_cnt width $clog2(WARMUP+1); no wrap (leaves WARM at WARMUP).
// TESTING
//  1. Reset, no seeds for 20 cycles -> taus_rst=1, seed_ready=1, rng_ready=0,
//     taus_s* = defaults throughout.
//  2. Stream 32'hDEADBEEF, 32'h12345678, 32'h0BADF00D back to back -> 1-cycle
//     taus_rst pulse, taus_s* equal those words, seed_fixed=000, rng_ready high
//     exactly WARMUP+1 cycles after 3rd transfer edge.
//  3. Seeds 1, 7, 15 -> taus_s* = DEFAULT_S0/1/2, seed_fixed=111; seeds 2, 8, 16
//     -> passed unchanged, seed_fixed=000.
//  4. seed_valid gaps of 5 cycles between words -> same result as scenario 2;
//     seed_ready low during LOAD/WARM even with seed_valid held high.
//  5. From READY, send word 32'h00000100 -> rng_ready drops next edge, taus_rst stays
//     0 until the 3rd word; new seeds appear only at LOAD.
//  6. Assert reset after 2nd word and again mid-WARM -> all outputs at reset values
//     next edge; a following full 3-word load behaves as scenario 2.

Source files
------------

// File: rtl/taus_seed_loader.sv
// ---------------------------------------------------------------------------
// taus_seed_loader
//
// Seeding front end for the Tausworthe uniform generator of the Box-Muller
// RNG. It collects three 32-bit seed words (s0, s1, s2) over a valid/ready
// stream and replaces any seed below the Tausworthe minimum with a default.
// It then strobes the generator's reset/seed-load input and keeps rng_ready
// low for WARMUP cycles, so the first, correlated outputs are never consumed.
//
// Ports
//   clk         in   1   system clock, all state on the rising edge
//   reset       in   1   synchronous, active-high reset
//   seed_valid  in   1   seed_data holds a word
//   seed_data   in   32  seed word, sent in the order s0, s1, s2
//   seed_ready  out  1   loader accepts a word this cycle
//   taus_rst    out  1   reset/seed-load strobe to the generator
//   taus_s0/1/2 out  32  validated seeds to the generator
//   seed_fixed  out  3   bit i set if seed si was replaced at the last load
//   rng_ready   out  1   generator output may be consumed
// ---------------------------------------------------------------------------
module taus_seed_loader #(
    parameter int          WARMUP     = 8,
    parameter logic [31:0] DEFAULT_S0 = 32'h0000_1234,
    parameter logic [31:0] DEFAULT_S1 = 32'h0000_5678,
    parameter logic [31:0] DEFAULT_S2 = 32'h0009_ABCD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        seed_valid,
    input  logic [31:0] seed_data,
    output logic        seed_ready,
    output logic        taus_rst,
    output logic [31:0] taus_s0,
    output logic [31:0] taus_s1,
    output logic [31:0] taus_s2,
    output logic [2:0]  seed_fixed,
    output logic        rng_ready
);

    localparam int WW = $clog2(WARMUP + 1);
    localparam logic [WW-1:0] WARM_ONE  = WW'(1);
    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        LOAD    = 3'd2,
        WARM    = 3'd3,
        READY   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      word_cnt_q, word_cnt_d;
    logic [WW-1:0]   warm_cnt_q, warm_cnt_d;
    logic [31:0]     stage0_q, stage0_d;
    logic [31:0]     stage1_q, stage1_d;
    logic            seed_ready_q, seed_ready_d;
    logic            taus_rst_q, taus_rst_d;
    logic [31:0]     taus_s0_q, taus_s0_d;
    logic [31:0]     taus_s1_q, taus_s1_d;
    logic [31:0]     taus_s2_q, taus_s2_d;
    logic [2:0]      seed_fixed_q, seed_fixed_d;
    logic            rng_ready_q, rng_ready_d;

    logic            xfer;
    logic            bad0, bad1, bad2;

    // seed_ready is registered, so a transfer is decided by the flopped value.
    assign xfer = seed_valid & seed_ready_q;

    // Validation of the complete seed set; s2 is the word arriving right now.
    assign bad0 = (stage0_q  < 32'd2);
    assign bad1 = (stage1_q  < 32'd8);
    assign bad2 = (seed_data < 32'd16);

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        warm_cnt_d   = warm_cnt_q;
        stage0_d     = stage0_q;
        stage1_d     = stage1_q;
        taus_rst_d   = taus_rst_q;
        taus_s0_d    = taus_s0_q;
        taus_s1_d    = taus_s1_q;
        taus_s2_d    = taus_s2_q;
        seed_fixed_d = seed_fixed_q;
        rng_ready_d  = rng_ready_q;

        case (state_q)
            IDLE: begin
                taus_rst_d = 1'b1;
                if (xfer) begin
                    state_d    = COLLECT;
                    word_cnt_d = 2'd1;
                    stage0_d   = seed_data;
                end
            end
            COLLECT: begin
                // taus_rst keeps its value: frozen when coming from IDLE,
                // running on the old seed when re-seeding from READY.
                if (xfer) begin
                    if (word_cnt_q == 2'd1) begin
                        stage1_d   = seed_data;
                        word_cnt_d = 2'd2;
                    end else begin
                        state_d      = LOAD;
                        word_cnt_d   = 2'd0;
                        taus_rst_d   = 1'b1;
                        taus_s0_d    = bad0 ? DEFAULT_S0 : stage0_q;
                        taus_s1_d    = bad1 ? DEFAULT_S1 : stage1_q;
                        taus_s2_d    = bad2 ? DEFAULT_S2 : seed_data;
                        seed_fixed_d = {bad2, bad1, bad0};
                    end
                end
            end
            LOAD: begin
                state_d    = WARM;
                warm_cnt_d = '0;
                taus_rst_d = 1'b0;
            end
            WARM: begin
                // The count reaches WARMUP on the edge that enters READY.
                warm_cnt_d = warm_cnt_q + WARM_ONE;
                if (warm_cnt_d == WARM_LAST) begin
                    state_d     = READY;
                    rng_ready_d = 1'b1;
                end
            end
            READY: begin
                if (xfer) begin
                    state_d     = COLLECT;
                    word_cnt_d  = 2'd1;
                    stage0_d    = seed_data;
                    rng_ready_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        seed_ready_d = (state_d == IDLE) || (state_d == COLLECT) || (state_d == READY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            word_cnt_q   <= 2'd0;
            warm_cnt_q   <= '0;
            stage0_q     <= 32'd0;
            stage1_q     <= 32'd0;
            seed_ready_q <= 1'b1;
            taus_rst_q   <= 1'b1;
            taus_s0_q    <= DEFAULT_S0;
            taus_s1_q    <= DEFAULT_S1;
            taus_s2_q    <= DEFAULT_S2;
            seed_fixed_q <= 3'b000;
            rng_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            warm_cnt_q   <= warm_cnt_d;
            stage0_q     <= stage0_d;
            stage1_q     <= stage1_d;
            seed_ready_q <= seed_ready_d;
            taus_rst_q   <= taus_rst_d;
            taus_s0_q    <= taus_s0_d;
            taus_s1_q    <= taus_s1_d;
            taus_s2_q    <= taus_s2_d;
            seed_fixed_q <= seed_fixed_d;
            rng_ready_q  <= rng_ready_d;
        end
    end

    assign seed_ready = seed_ready_q;
    assign taus_rst   = taus_rst_q;
    assign taus_s0    = taus_s0_q;
    assign taus_s1    = taus_s1_q;
    assign taus_s2    = taus_s2_q;
    assign seed_fixed = seed_fixed_q;
    assign rng_ready  = rng_ready_q;

endmodule
